pid_coinc_trigger: RTL
======================

Name: pid_coinc_trigger

Overview:
Downstream of the per-channel fine-time PID discriminators. Collects the Electron/Muon/Pion match pulses from NCH detector channels on the 50 MHz domain and forms a multiplicity coincidence per particle type. Applies per-type prescale, deadtime and DAQ-busy gating, then issues a one-cycle trigger with a type code. Configuration and scalers are on the local bus, sharing the OR'd DataOut scheme used by the channel blocks.

Parameters:
NCH, 8, number of channel inputs per type (1..16)
BASE, 8'hC0, local-bus base address; registers occupy BASE+0 .. BASE+8
DEAD_DEF, 16'd20, reset value of the DEADTIME register

Ports:
clk  in  1  50 MHz system clock (the channel blocks' clk[2])
rst  in  1  synchronous, active-high reset
electron  in  NCH  per-channel electron match pulses
muon  in  NCH  per-channel muon match pulses
pion  in  NCH  per-channel pion match pulses
busy_in  in  1  DAQ busy; blocks new triggers while high
trig_out  out  1  one-cycle trigger pulse
trig_type  out  2  01 electron, 10 muon, 11 pion; held until next trigger; 00 after reset
DataOut  out  32  bus read data; 0 when not addressed
DataIn  in  32  bus write data
Address  in  8  bus address
Read  in  1  bus read strobe
Write  in  1  bus write strobe
ack  out  1  high one cycle after any Read/Write hitting BASE..BASE+8

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high; every register, counter and the FSM clear on the clk edge where rst=1.
- Register map (offset from BASE):
  - 0 CTRL: [0] enable; [1] E_en; [2] M_en; [3] P_en; [7:4] window W; [11:8] multiplicity M. Reset 0x0000020F: enabled, all types, W=0, M=2.
  - 1 MASK[NCH-1:0]: reset all ones.
  - 2 PRESC: [7:0] P, [15:8] M, [23:16] E. A value N accepts 1 of every N+1 coincidences. Reset 0.
  - 3 DEADTIME[15:0]: reset DEAD_DEF.
  - 4/5/6: raw E/M/P coincidence scalers (read-only).
  - 7: accepted-trigger scaler. Any write to 7 clears all four scalers.
- Read path: DataOut is combinational while Read is high and Address matches; otherwise 0. Writes take effect on the clk edge.
- Input stage: inputs are registered once (in_q).
- Per-bit stretcher (3NCH bits, 4-bit counter each):
  - If in_q is high, cnt<=W; else if cnt!=0, cnt<=cnt-1.
  - s = in_q | (cnt!=0), so a pulse is widened by W cycles.
- Coincidence: coinc_X is registered: popcount(s_X & MASK) >= M. M=0 is treated as 1.
- Raw scalers: increment on each rising edge of coinc_X, whatever the FSM state. 32-bit, saturating at 0xFFFFFFFF.
- FSM states IDLE, FIRE, DEAD, WAITB:
  - IDLE: requires enable=1. Candidate types are those with coinc_X=1 and X_en=1. Select the highest priority: pion > muon > electron.
    - If the selected type's prescale counter equals PRESC_X: clear that counter, go to FIRE, latch trig_type.
    - Otherwise: increment that counter, stay in IDLE.
    - Lower-priority prescalers are untouched.
  - FIRE: trig_out=1 for exactly this cycle; accepted scaler +1 (saturating). Next state is DEAD, or WAITB if DEADTIME=0.
  - DEAD: counts DEADTIME cycles, then goes to WAITB.
  - WAITB: stays while busy_in=1; goes to IDLE when busy_in=0.
- Latency: inputs meeting the coincidence at clk edge T give trig_out high in the cycle after edge T+3. Stages: in_q, s/coinc, FSM, FIRE.
- Boundary conditions:
  - enable cleared in any state: next state is IDLE and trig_out stays 0. A FIRE already registered still completes its one cycle.
  - CTRL, PRESC or DEADTIME written mid-deadtime: used by the next decision. A running DEAD count is not reloaded.
  - PRESC written: resets all prescale counters.
  - Coincidences arriving during FIRE/DEAD/WAITB: counted by the raw scalers, never triggered and never queued.
  - Reset during any state returns the FSM to IDLE with trig_out=0 on that edge.

Optional Feature:
PID_TRIG_TS_EN
- Defined: adds a 32-bit free-running cycle counter (cleared by rst, wraps). It is latched into a timestamp register on entry to FIRE, readable at BASE+8, and ack covers BASE+8.
- Undefined: no counter or register; BASE+8 reads 0 and gives no ack.

Test Plan:
- Reset defaults: after rst, read BASE+0..3 -> 0x0000020F, 0x000000FF, 0, 0x14; trig_out=0, trig_type=00.
- Two-fold muon coincidence: muon[0] and muon[3] pulsed the same cycle, W=0 -> exactly one trig_out, 4 cycles later, trig_type=10; scaler5=1, scaler7=1.
- Window: W=3, muon[1] then muon[2] 3 cycles later -> trigger. Same pair 5 cycles apart -> no trigger, scaler5=0.
- Priority and prescale: E and P coincident, PRESC P=2 -> first two events give no trigger, third gives trig_type=11. The electron prescaler is unchanged; scaler4 counts all three.
- Deadtime/busy: DEADTIME=10, busy_in held high 20 cycles after trigger, coincidences injected every 4 cycles -> no trig_out until busy_in falls. Raw scaler counts every one of them.
- Scaler clear and MASK: write BASE+7 -> all scalers 0. MASK=0x01, M=2 -> coincidences never fire.

Source files
------------

// File: rtl/pid_coinc_trigger.sv
// Multiplicity coincidence trigger for per-channel electron/muon/pion PID match pulses.
// Optional macro PID_TRIG_TS_EN adds a free-running cycle counter and a trigger timestamp at BASE+8.
module pid_coinc_trigger #(
    parameter int unsigned NCH      = 8,
    parameter logic [7:0]  BASE     = 8'hC0,
    parameter logic [15:0] DEAD_DEF = 16'd20
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] electron,
    input  logic [NCH-1:0] muon,
    input  logic [NCH-1:0] pion,
    input  logic           busy_in,
    output logic           trig_out,
    output logic [1:0]     trig_type,
    output logic [31:0]    DataOut,
    input  logic [31:0]    DataIn,
    input  logic [7:0]     Address,
    input  logic           Read,
    input  logic           Write,
    output logic           ack
);

    localparam int unsigned NB = 3 * NCH;

`ifdef PID_TRIG_TS_EN
    localparam logic [7:0] LAST_OFF = 8'd8;
`else
    localparam logic [7:0] LAST_OFF = 8'd7;
`endif

    typedef enum logic [1:0] {StIdle, StFire, StDead, StWaitB} state_e;

    // ------------------------------------------------------------------
    // Local bus decode and configuration registers
    // ------------------------------------------------------------------
    logic [7:0]     offset;
    logic           hit;
    logic           wr_en;
    logic           rd_en;
    logic           presc_wr;
    logic           sc_clr;

    logic [11:0]    ctrl_q;
    logic [NCH-1:0] mask_q;
    logic [23:0]    presc_q;
    logic [15:0]    dead_q;
    logic           ack_q;

    assign offset   = Address - BASE;
    assign hit      = (offset <= LAST_OFF);
    assign wr_en    = Write & hit;
    assign rd_en    = Read & hit;
    assign presc_wr = wr_en && (offset == 8'd2);
    assign sc_clr   = wr_en && (offset == 8'd7);

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q  <= 12'h20F;
            mask_q  <= '1;
            presc_q <= '0;
            dead_q  <= DEAD_DEF;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= (Read | Write) & hit;
            if (wr_en) begin
                case (offset)
                    8'd0:    ctrl_q  <= DataIn[11:0];
                    8'd1:    mask_q  <= DataIn[NCH-1:0];
                    8'd2:    presc_q <= DataIn[23:0];
                    8'd3:    dead_q  <= DataIn[15:0];
                    default: ;
                endcase
            end
        end
    end

    assign ack = ack_q;

    logic       enable;
    logic [2:0] type_en;
    logic [3:0] win;
    logic [3:0] mult_eff;

    assign enable   = ctrl_q[0];
    assign type_en  = ctrl_q[3:1];
    assign win      = ctrl_q[7:4];
    assign mult_eff = (ctrl_q[11:8] == 4'd0) ? 4'd1 : ctrl_q[11:8];

    // ------------------------------------------------------------------
    // Input register, per-bit stretcher and coincidence
    // Bit layout of in_q / s: [NCH-1:0] electron, then muon, then pion.
    // ------------------------------------------------------------------
    logic [NB-1:0]      in_q;
    logic [NB-1:0][3:0] cnt_q;
    logic [NB-1:0]      s;
    logic [2:0][4:0]    pop;
    logic [2:0]         coinc_d;
    logic [2:0]         coinc_q;
    logic [2:0]         coinc_prev_q;
    logic [2:0]         coinc_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            in_q  <= '0;
            cnt_q <= '0;
        end else begin
            in_q <= {pion, muon, electron};
            for (int i = 0; i < NB; i++) begin
                if (in_q[i]) begin
                    cnt_q[i] <= win;
                end else if (cnt_q[i] != 4'd0) begin
                    cnt_q[i] <= cnt_q[i] - 4'd1;
                end
            end
        end
    end

    always_comb begin
        s = '0;
        for (int i = 0; i < NB; i++) begin
            s[i] = in_q[i] | (cnt_q[i] != 4'd0);
        end
    end

    always_comb begin
        pop     = '0;
        coinc_d = '0;
        for (int t = 0; t < 3; t++) begin
            for (int c = 0; c < NCH; c++) begin
                pop[t] = pop[t] + {4'd0, s[t*NCH + c] & mask_q[c]};
            end
            coinc_d[t] = (pop[t] >= {1'b0, mult_eff});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            coinc_q      <= '0;
            coinc_prev_q <= '0;
        end else begin
            coinc_q      <= coinc_d;
            coinc_prev_q <= coinc_q;
        end
    end

    assign coinc_rise = coinc_q & ~coinc_prev_q;

    // ------------------------------------------------------------------
    // Trigger FSM with per-type prescale and deadtime
    // ------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [15:0]     dead_cnt_q, dead_cnt_d;
    logic [2:0][7:0] pcnt_q, pcnt_d;
    logic [2:0][7:0] presc_val;
    logic [1:0]      type_q, type_d;
    logic            trig_q;
    logic [2:0]      cand;
    logic [1:0]      sel;

    assign presc_val = {presc_q[7:0], presc_q[15:8], presc_q[23:16]};
    assign cand      = coinc_q & type_en;

    always_comb begin
        sel        = 2'd0;
        state_d    = state_q;
        dead_cnt_d = dead_cnt_q;
        pcnt_d     = pcnt_q;
        type_d     = type_q;

        // Pion outranks muon outranks electron.
        if (cand[2]) begin
            sel = 2'd2;
        end else if (cand[1]) begin
            sel = 2'd1;
        end

        case (state_q)
            StIdle: begin
                if (enable && (cand != 3'b000)) begin
                    if (pcnt_q[sel] == presc_val[sel]) begin
                        pcnt_d[sel] = 8'd0;
                        state_d     = StFire;
                        type_d      = sel + 2'd1;
                    end else begin
                        pcnt_d[sel] = pcnt_q[sel] + 8'd1;
                    end
                end
            end
            StFire: begin
                if (dead_q == 16'd0) begin
                    state_d = StWaitB;
                end else begin
                    state_d    = StDead;
                    dead_cnt_d = dead_q;
                end
            end
            StDead: begin
                if (dead_cnt_q <= 16'd1) begin
                    state_d = StWaitB;
                end else begin
                    dead_cnt_d = dead_cnt_q - 16'd1;
                end
            end
            StWaitB: begin
                if (!busy_in) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (!enable) begin
            state_d = StIdle;
        end
        if (presc_wr) begin
            pcnt_d = '0;
        end
    end

    // trig_out follows FIRE by one register stage, so a registered FIRE always completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            dead_cnt_q <= '0;
            pcnt_q     <= '0;
            type_q     <= 2'b00;
            trig_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dead_cnt_q <= dead_cnt_d;
            pcnt_q     <= pcnt_d;
            type_q     <= type_d;
            trig_q     <= (state_q == StFire);
        end
    end

    assign trig_out  = trig_q;
    assign trig_type = type_q;

    // ------------------------------------------------------------------
    // Scalers (saturating); a write to offset 7 clears all four
    // ------------------------------------------------------------------
    logic [2:0][31:0] raw_q;
    logic [31:0]      acc_q;

    always_ff @(posedge clk) begin
        if (rst || sc_clr) begin
            raw_q <= '0;
            acc_q <= '0;
        end else begin
            for (int t = 0; t < 3; t++) begin
                if (coinc_rise[t] && (raw_q[t] != 32'hFFFF_FFFF)) begin
                    raw_q[t] <= raw_q[t] + 32'd1;
                end
            end
            if ((state_q == StFire) && (acc_q != 32'hFFFF_FFFF)) begin
                acc_q <= acc_q + 32'd1;
            end
        end
    end

`ifdef PID_TRIG_TS_EN
    logic [31:0] ts_cnt_q;
    logic [31:0] ts_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_cnt_q <= '0;
            ts_q     <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + 32'd1;
            if ((state_q == StIdle) && (state_d == StFire)) begin
                ts_q <= ts_cnt_q;
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Read mux: zero unless addressed, so DataOut can be OR'd on the bus
    // ------------------------------------------------------------------
    always_comb begin
        DataOut = '0;
        if (rd_en) begin
            case (offset)
                8'd0:    DataOut = {20'd0, ctrl_q};
                8'd1:    DataOut[NCH-1:0] = mask_q;
                8'd2:    DataOut = {8'd0, presc_q};
                8'd3:    DataOut = {16'd0, dead_q};
                8'd4:    DataOut = raw_q[0];
                8'd5:    DataOut = raw_q[1];
                8'd6:    DataOut = raw_q[2];
                8'd7:    DataOut = acc_q;
`ifdef PID_TRIG_TS_EN
                8'd8:    DataOut = ts_q;
`endif
                default: DataOut = '0;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^DataIn[31:24];

endmodule
